// File: rtl/lvds_pkg.sv
// ----------------------------------------------------------------------------
// lvds_pkg
// Shared definitions for the LVDS sync decoder: FSM state encoding, the
// position of the XY flag bits (as offsets below the word MSB, so they scale
// with DATA_WIDTH), the 8-bit XY reference codes and the pixel counter width.
// ----------------------------------------------------------------------------
package lvds_pkg;

    typedef enum logic [2:0] {
        ST_SEARCH,
        ST_PRE1,
        ST_PRE2,
        ST_PRE3,
        ST_ACTIVE,
        ST_BLANK,
        ST_EXPECT_EAV
    } lvds_state_e;

    // XY layout: MSB must be 1, V one bit below it, H two bits below it.
    localparam int unsigned XY_V_OFS = 1;
    localparam int unsigned XY_H_OFS = 2;

    // Reference XY codes for 8-bit words.
    localparam logic [7:0] XY8_SAV_ACTIVE = 8'h80;
    localparam logic [7:0] XY8_EAV_ACTIVE = 8'hA0;
    localparam logic [7:0] XY8_SAV_BLANK  = 8'hC0;
    localparam logic [7:0] XY8_EAV_BLANK  = 8'hE0;

    localparam int unsigned PIX_CNT_W = 16;

endpackage

// File: rtl/lvds_sync_match.sv
// ----------------------------------------------------------------------------
// lvds_sync_match
// Combinational classifier for one lane-0 word.
//   word_i     : lane-0 deserialized word
//   is_ones_o  : word is all ones (preamble start)
//   is_zero_o  : word is all zeros (preamble body)
//   xy_valid_o : MSB set, word usable as an XY code
//   v_o        : XY vertical-blank flag
//   h_o        : XY H flag (0 = SAV, 1 = EAV)
// ----------------------------------------------------------------------------
module lvds_sync_match
    import lvds_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] word_i,
    output logic                  is_ones_o,
    output logic                  is_zero_o,
    output logic                  xy_valid_o,
    output logic                  v_o,
    output logic                  h_o
);

    assign is_ones_o  = &word_i;
    assign is_zero_o  = ~|word_i;
    assign xy_valid_o = word_i[DATA_WIDTH-1];
    assign v_o        = word_i[DATA_WIDTH-1-XY_V_OFS];
    assign h_o        = word_i[DATA_WIDTH-1-XY_H_OFS];

endmodule

// File: rtl/lvds_sync_decoder.sv
// ----------------------------------------------------------------------------
// lvds_sync_decoder
// Tracks SAV/EAV sync codes on lane 0 of a deserialized LVDS stream and
// forwards the active pixel words of every lane as a stream.
//   clk        : rx word clock, only clock
//   reset      : asynchronous, active-low reset
//   align_done : lanes aligned; low forces the decoder back to search
//   rx_data    : one word per lane per clock, lane 0 in the LSBs
//   tdata      : active pixel words (held while tvalid is low)
//   tvalid     : tdata valid, no backpressure
//   tuser      : first pixel of a frame
//   tlast      : last pixel of a line
//   locked     : decoder is tracking line structure
//   sync_err   : one-cycle pulse on a broken EAV after an active line
// ----------------------------------------------------------------------------
module lvds_sync_decoder
    import lvds_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CHANNEL_RX = 1,
    parameter int unsigned H_ACTIVE   = 1920
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             align_done,
    input  logic [DATA_WIDTH*CHANNEL_RX-1:0] rx_data,
    output logic [DATA_WIDTH*CHANNEL_RX-1:0] tdata,
    output logic                             tvalid,
    output logic                             tuser,
    output logic                             tlast,
    output logic                             locked,
    output logic                             sync_err
);

    localparam logic [PIX_CNT_W-1:0] LAST_IDX = PIX_CNT_W'(H_ACTIVE - 1);

    logic is_ones, is_zero, xy_valid, xy_v, xy_h;

    lvds_sync_match #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_match (
        .word_i     (rx_data[DATA_WIDTH-1:0]),
        .is_ones_o  (is_ones),
        .is_zero_o  (is_zero),
        .xy_valid_o (xy_valid),
        .v_o        (xy_v),
        .h_o        (xy_h)
    );

    lvds_state_e                      state_q, state_d;
    logic [PIX_CNT_W-1:0]             cnt_q, cnt_d;
    logic [1:0]                       eav_idx_q, eav_idx_d;
    logic                             frame_q, frame_d;
    logic [DATA_WIDTH*CHANNEL_RX-1:0] tdata_q, tdata_d;
    logic                             tvalid_q, tvalid_d;
    logic                             tuser_q, tuser_d;
    logic                             tlast_q, tlast_d;
    logic                             locked_q, locked_d;
    logic                             sync_err_q, sync_err_d;
    logic                             eav_ok;

    // Word expected at the current position of the trailing EAV.
    always_comb begin
        case (eav_idx_q)
            2'd0:       eav_ok = is_ones;
            2'd1, 2'd2: eav_ok = is_zero;
            default:    eav_ok = xy_valid && xy_h;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        eav_idx_d  = eav_idx_q;
        frame_d    = frame_q;
        tdata_d    = tdata_q;
        tvalid_d   = 1'b0;
        tuser_d    = 1'b0;
        tlast_d    = 1'b0;
        locked_d   = locked_q;
        sync_err_d = 1'b0;

        if (!align_done) begin
            state_d   = ST_SEARCH;
            locked_d  = 1'b0;
            eav_idx_d = '0;
        end else begin
            case (state_q)
                ST_SEARCH, ST_BLANK: begin
                    if (is_ones) state_d = ST_PRE1;
                end
                ST_PRE1, ST_PRE2: begin
                    if (is_zero)      state_d = (state_q == ST_PRE1) ? ST_PRE2 : ST_PRE3;
                    else if (is_ones) state_d = ST_PRE1;
                    else              state_d = ST_SEARCH;
                end
                ST_PRE3: begin
                    state_d = ST_SEARCH;
                    if (xy_valid) begin
                        // Any V=1 code arms tuser for the next active line.
                        if (xy_v) frame_d = 1'b1;
                        if (!xy_h) begin
                            cnt_d   = '0;
                            state_d = xy_v ? ST_BLANK : ST_ACTIVE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    tvalid_d = 1'b1;
                    tdata_d  = rx_data;
                    tuser_d  = frame_q && (cnt_q == '0);
                    tlast_d  = (cnt_q == LAST_IDX);
                    if (cnt_q == '0) frame_d = 1'b0;
                    if (cnt_q == LAST_IDX) begin
                        state_d   = ST_EXPECT_EAV;
                        eav_idx_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_EXPECT_EAV: begin
                    if (!eav_ok) begin
                        sync_err_d = 1'b1;
                        locked_d   = 1'b0;
                        state_d    = ST_SEARCH;
                    end else if (eav_idx_q == 2'd3) begin
                        locked_d = 1'b1;
                        if (xy_v) frame_d = 1'b1;
                        state_d = ST_SEARCH;
                    end else begin
                        eav_idx_d = eav_idx_q + 2'd1;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_SEARCH;
            cnt_q      <= '0;
            eav_idx_q  <= '0;
            frame_q    <= 1'b1;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tuser_q    <= 1'b0;
            tlast_q    <= 1'b0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            eav_idx_q  <= eav_idx_d;
            frame_q    <= frame_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tuser_q    <= tuser_d;
            tlast_q    <= tlast_d;
            locked_q   <= locked_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign tdata    = tdata_q;
    assign tvalid   = tvalid_q;
    assign tuser    = tuser_q;
    assign tlast    = tlast_q;
    assign locked   = locked_q;
    assign sync_err = sync_err_q;

endmodule

// File: doc/lvds_sync_decoder.md
LVDS_SYNC_DECODER -- requirements
Module: lvds_sync_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per deserialized word per channel (min 4).
REQ-002 SHALL have parameter CHANNEL_RX, default 1: number of parallel LVDS data lanes.
REQ-003 SHALL have parameter H_ACTIVE, default 1920: active words per line per lane (min 2, max 65535).
REQ-004 SHALL have port clk  input  1: rx word clock (deserializer clkdiv domain); only clock.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port align_done  input  1: all lanes bit/word aligned; low forces search.
REQ-007 SHALL have port rx_data  input  DATA_WIDTH*CHANNEL_RX: one word per lane per clk, lane 0 in LSBs.
REQ-008 SHALL have port tdata  output  DATA_WIDTH*CHANNEL_RX: active pixel words.
REQ-009 SHALL have port tvalid  output  1: tdata valid; no backpressure.
REQ-010 SHALL have port tuser  output  1: first pixel of a frame.
REQ-011 SHALL have port tlast  output  1: last pixel of a line.
REQ-012 SHALL have port locked  output  1: decoder tracking line structure.
REQ-013 SHALL have port sync_err  output  1: one-cycle pulse on structure violation.

Function
REQ-014 Sync codes SHALL be detected on lane 0 only: words all-ones, zero, zero, XY on four consecutive cycles.
REQ-015 XY SHALL decode as: MSB must be 1; bit DATA_WIDTH-2 = V (1 = vertical blank); bit DATA_WIDTH-3 = H (0 = SAV, 1 = EAV); lower bits ignored. For DATA_WIDTH 8: 0x80 active SAV, 0xA0 active EAV, 0xC0 blank SAV, 0xE0 blank EAV.
REQ-016 States SHALL be SEARCH, PRE1, PRE2, PRE3, ACTIVE, BLANK, EXPECT_EAV.
REQ-017 SEARCH->PRE1 on all-ones; PRE1->PRE2 on zero; PRE2->PRE3 on zero; any other word in PRE1/PRE2 SHALL return to SEARCH (to PRE1 if the word is all-ones).
REQ-018 In PRE3: active SAV -> ACTIVE; blank SAV -> BLANK; EAV or invalid XY (MSB 0) -> SEARCH.
REQ-019 ACTIVE SHALL forward exactly H_ACTIVE words (all lanes) and then enter EXPECT_EAV; words are not inspected for sync in ACTIVE.
REQ-020 EXPECT_EAV SHALL require preamble plus EAV on the next 4 words; match -> SEARCH with locked held high; mismatch at any word -> sync_err pulse, locked low, SEARCH.
REQ-021 BLANK SHALL behave as SEARCH, forwarding nothing; its EAV keeps locked high.
REQ-022 locked SHALL rise on the first valid EAV after a complete active line and fall on any sync_err or align_done low.
REQ-023 Latency SHALL be one clk: rx_data word n of active line appears on tdata with tvalid=1 on the following cycle.
REQ-024 tlast SHALL be 1 with the H_ACTIVE-th word of every active line.
REQ-025 tuser SHALL be 1 with the first word of the first active line following any blank SAV/EAV (V=1); subsequent lines tuser=0.
REQ-026 Pixel counter SHALL be 16 bits, clear on SAV, no wrap beyond H_ACTIVE.
REQ-027 align_done low in any state SHALL force SEARCH next cycle, tvalid=0, locked=0, no sync_err.
REQ-028 An all-ones/zero/zero/XY pattern inside ACTIVE payload SHALL be forwarded as pixels.
REQ-029 tdata SHALL hold its last value when tvalid=0.

Reset
REQ-030 On reset low: state SEARCH, pixel counter 0, tdata 0, tvalid 0, tuser 0, tlast 0, locked 0, sync_err 0, frame-start flag set (first active line after reset carries tuser).
REQ-031 Reset assertion mid-line SHALL drop tvalid immediately (asynchronously); no partial line completes after release.

Structure
REQ-032 A shared package lvds_pkg SHALL hold the state encoding, XY bit positions and SAV/EAV XY constants.
REQ-033 One sub-module lvds_sync_match SHALL decode lane-0 word into is_ones, is_zero, xy_valid, v, h flags.

Verification (DATA_WIDTH 8, CHANNEL_RX 1, H_ACTIVE 4)
REQ-034 FF 00 00 C0, FF 00 00 E0, FF 00 00 80, 11 22 33 44, FF 00 00 A0 -> tdata 11,22,33,44 one cycle later, tuser on 11, tlast on 44, locked high after A0.
REQ-035 Second active line FF 00 00 80, 55 66 77 88, FF 00 00 A0 -> tuser 0, tlast on 88, locked stays 1.
REQ-036 Active line then FF 00 01 A0 -> sync_err one-cycle pulse on 01 word, locked 0, no tvalid until next SAV.
REQ-037 Payload FF 00 00 A0 inside active line -> all four forwarded as pixels, tlast on A0, no state change.
REQ-038 align_done dropped after second pixel -> tvalid 0 next cycle, locked 0, sync_err 0; recovery on next SAV.
REQ-039 reset low asserted after pixel 22 -> all outputs 0 immediately; after release first SAV 0x80 line carries tuser=1.
